sdram_arbit: RTL and testbench

//  Owns the single SDRAM command/address/data bus and sequences the requester blocks onto it.

---
 rtl/sdram_arbit_if.sv | 78 +++++++
 rtl/sdram_arbit.sv | 165 ++++++++++++++++
 tb/tb_sdram_arbit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_if.sv
// ----------------------------------------------------------------------------
// sdram_arbit_if
//   Bundles every signal exchanged between the SDRAM bus arbiter and the
//   blocks around it: the requester blocks (init, auto-refresh, write, read)
//   and the SDRAM device pins.
//
//   modport slave  : arbiter view. Requester commands in, grants and pins out.
//   modport master : environment view (requesters + pad logic), the mirror.
//
//   Signal groups
//     init_*   : power-up sequencer command/bank/address and its done flag
//     aref_*   : refresh request/end/command/address and refresh grant
//     wr_*     : write request/end/command/bank/address/data and write grant
//     rd_*     : read request/end/command/bank/address and read grant
//     sdram_*  : muxed command/bank/address, dq drive value and output enable
// ----------------------------------------------------------------------------
interface sdram_arbit_if #(
   parameter int ADDR_W = 13,
   parameter int BANK_W = 2,
   parameter int DATA_W = 16
);
   logic              init_end;
   logic [3:0]        init_cmd;
   logic [BANK_W-1:0] init_bank;
   logic [ADDR_W-1:0] init_addr;

   logic              aref_req;
   logic              aref_end;
   logic [3:0]        aref_cmd;
   logic [ADDR_W-1:0] aref_addr;
   logic              aref_en;

   logic              wr_req;
   logic              wr_end;
   logic [3:0]        wr_sdram_cmd;
   logic [BANK_W-1:0] wr_sdram_bank;
   logic [ADDR_W-1:0] wr_sdram_addr;
   logic              wr_sdram_en;
   logic [DATA_W-1:0] wr_sdram_data;
   logic              wr_en;

   logic              rd_req;
   logic              rd_end;
   logic [3:0]        rd_sdram_cmd;
   logic [BANK_W-1:0] rd_sdram_bank;
   logic [ADDR_W-1:0] rd_sdram_addr;
   logic              rd_en;

   logic [3:0]        sdram_cmd;
   logic [BANK_W-1:0] sdram_bank;
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_dq_out;
   logic              sdram_dq_oe;

   modport slave (
      input  init_end, init_cmd, init_bank, init_addr,
      input  aref_req, aref_end, aref_cmd, aref_addr,
      output aref_en,
      input  wr_req, wr_end, wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr,
      input  wr_sdram_en, wr_sdram_data,
      output wr_en,
      input  rd_req, rd_end, rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr,
      output rd_en,
      output sdram_cmd, sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
   );

   modport master (
      output init_end, init_cmd, init_bank, init_addr,
      output aref_req, aref_end, aref_cmd, aref_addr,
      input  aref_en,
      output wr_req, wr_end, wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr,
      output wr_sdram_en, wr_sdram_data,
      input  wr_en,
      output rd_req, rd_end, rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr,
      input  rd_en,
      input  sdram_cmd, sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
   );
endinterface

// File: rtl/sdram_arbit.sv
// ----------------------------------------------------------------------------
// sdram_arbit
//   Owns the single SDRAM command/address/data bus. While the device is being
//   initialised the init sequencer's command passes straight through. After
//   init_end, one of auto-refresh / write / read is granted at a time and its
//   command, bank, address and write data are muxed onto the pins.
//
//   Ports
//     arb_clk : clock, rising edge
//     arb_rst : asynchronous active-high reset
//     bus     : sdram_arbit_if.slave (requester signals, grants, device pins)
//
//   Parameters
//     ADDR_W / BANK_W / DATA_W : must match the connected interface widths
//     CMD_NOP : {cs_n,ras_n,cas_n,we_n} driven while nobody owns the bus
//     FAIR_RW : 1 = a read still pending when a write finishes wins the next
//               write/read tie once, so continuous traffic alternates W,R,W,R
// ----------------------------------------------------------------------------
module sdram_arbit #(
   parameter int         ADDR_W  = 13,
   parameter int         BANK_W  = 2,
   parameter int         DATA_W  = 16,
   parameter logic [3:0] CMD_NOP = 4'b0111,
   parameter bit         FAIR_RW = 1'b1
) (
   input  logic          arb_clk,
   input  logic          arb_rst,
   sdram_arbit_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARBIT = 3'd1,
      S_AREF  = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t state_q;
   logic   aref_en_q;
   logic   wr_en_q;
   logic   rd_en_q;
   logic   rd_first_q;   // read was left waiting behind the last write

   // A write/read tie goes to the read only when fairness is enabled and the
   // read was already pending when the previous write finished.
   logic   rd_wins;
   assign rd_wins = FAIR_RW && rd_first_q;

   // Grants are registered alongside the state so a grant rises on the same
   // edge the state enters the matching burst state. Every burst returns to
   // ARBIT, which guarantees at least one NOP cycle between grants.
   always_ff @(posedge arb_clk or posedge arb_rst) begin
      if (arb_rst) begin
         state_q    <= S_IDLE;
         aref_en_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_first_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.init_end) begin
                  state_q <= S_ARBIT;
               end
            end
            S_ARBIT: begin
               if (bus.aref_req) begin
                  state_q   <= S_AREF;
                  aref_en_q <= 1'b1;
               end else if (bus.wr_req && bus.rd_req) begin
                  if (rd_wins) begin
                     state_q <= S_READ;
                     rd_en_q <= 1'b1;
                  end else begin
                     state_q <= S_WRITE;
                     wr_en_q <= 1'b1;
                  end
               end else if (bus.wr_req) begin
                  state_q <= S_WRITE;
                  wr_en_q <= 1'b1;
               end else if (bus.rd_req) begin
                  state_q <= S_READ;
                  rd_en_q <= 1'b1;
               end
            end
            S_AREF: begin
               if (bus.aref_end) begin
                  state_q   <= S_ARBIT;
                  aref_en_q <= 1'b0;
               end
            end
            S_WRITE: begin
               if (bus.wr_end) begin
                  state_q    <= S_ARBIT;
                  wr_en_q    <= 1'b0;
                  rd_first_q <= bus.rd_req;
               end
            end
            S_READ: begin
               if (bus.rd_end) begin
                  state_q    <= S_ARBIT;
                  rd_en_q    <= 1'b0;
                  rd_first_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               aref_en_q <= 1'b0;
               wr_en_q   <= 1'b0;
               rd_en_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.aref_en = aref_en_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.rd_en   = rd_en_q;

   // Pin mux follows the state directly, so a block's command reaches the
   // device in the same cycle its grant is high.
   logic [3:0]        cmd_mux;
   logic [BANK_W-1:0] bank_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic              dq_oe;

   always_comb begin
      cmd_mux  = CMD_NOP;
      bank_mux = {BANK_W{1'b0}};
      addr_mux = {ADDR_W{1'b0}};
      unique case (state_q)
         S_IDLE: begin
            cmd_mux  = bus.init_cmd;
            bank_mux = bus.init_bank;
            addr_mux = bus.init_addr;
         end
         S_AREF: begin
            cmd_mux  = bus.aref_cmd;
            addr_mux = bus.aref_addr;   // refresh ignores bank; hold it at 0
         end
         S_WRITE: begin
            cmd_mux  = bus.wr_sdram_cmd;
            bank_mux = bus.wr_sdram_bank;
            addr_mux = bus.wr_sdram_addr;
         end
         S_READ: begin
            cmd_mux  = bus.rd_sdram_cmd;
            bank_mux = bus.rd_sdram_bank;
            addr_mux = bus.rd_sdram_addr;
         end
         default: begin
            cmd_mux  = CMD_NOP;
         end
      endcase
   end

   assign dq_oe            = (state_q == S_WRITE) && bus.wr_sdram_en;
   assign bus.sdram_cmd    = cmd_mux;
   assign bus.sdram_bank   = bank_mux;
   assign bus.sdram_addr   = addr_mux;
   assign bus.sdram_dq_oe  = dq_oe;
   assign bus.sdram_dq_out = dq_oe ? bus.wr_sdram_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sdram_arbit.sv
// ----------------------------------------------------------------------------
// tb_sdram_arbit
//   Directed bench for sdram_arbit. Two instances: dut_f (FAIR_RW=1) carries
//   most sequences; dut_u (FAIR_RW=0) shares the same requester inputs and is
//   released from reset only for the write/read alternation sequence.
// ----------------------------------------------------------------------------
module tb_sdram_arbit;

   localparam logic [3:0] NOP = 4'b0111;

   logic clk = 1'b0;
   logic rst_f;
   logic rst_u;

   int n_checks = 0;
   int n_fail   = 0;

   sdram_arbit_if #(.ADDR_W(13), .BANK_W(2), .DATA_W(16)) bus_f ();
   sdram_arbit_if #(.ADDR_W(13), .BANK_W(2), .DATA_W(16)) bus_u ();

   sdram_arbit #(.ADDR_W(13), .BANK_W(2), .DATA_W(16), .CMD_NOP(NOP), .FAIR_RW(1'b1)) dut_f (
      .arb_clk (clk),
      .arb_rst (rst_f),
      .bus     (bus_f)
   );

   sdram_arbit #(.ADDR_W(13), .BANK_W(2), .DATA_W(16), .CMD_NOP(NOP), .FAIR_RW(1'b0)) dut_u (
      .arb_clk (clk),
      .arb_rst (rst_u),
      .bus     (bus_u)
   );

   // second instance sees exactly the same requester stimulus
   assign bus_u.init_end      = bus_f.init_end;
   assign bus_u.init_cmd      = bus_f.init_cmd;
   assign bus_u.init_bank     = bus_f.init_bank;
   assign bus_u.init_addr     = bus_f.init_addr;
   assign bus_u.aref_req      = bus_f.aref_req;
   assign bus_u.aref_end      = bus_f.aref_end;
   assign bus_u.aref_cmd      = bus_f.aref_cmd;
   assign bus_u.aref_addr     = bus_f.aref_addr;
   assign bus_u.wr_req        = bus_f.wr_req;
   assign bus_u.wr_end        = bus_f.wr_end;
   assign bus_u.wr_sdram_cmd  = bus_f.wr_sdram_cmd;
   assign bus_u.wr_sdram_bank = bus_f.wr_sdram_bank;
   assign bus_u.wr_sdram_addr = bus_f.wr_sdram_addr;
   assign bus_u.wr_sdram_en   = bus_f.wr_sdram_en;
   assign bus_u.wr_sdram_data = bus_f.wr_sdram_data;
   assign bus_u.rd_req        = bus_f.rd_req;
   assign bus_u.rd_end        = bus_f.rd_end;
   assign bus_u.rd_sdram_cmd  = bus_f.rd_sdram_cmd;
   assign bus_u.rd_sdram_bank = bus_f.rd_sdram_bank;
   assign bus_u.rd_sdram_addr = bus_f.rd_sdram_addr;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end else begin
         $display("ok   %s act=%h", tag, act);
      end
   endtask

   // {aref_en, wr_en, rd_en}
   function automatic logic [31:0] gnt_f();
      return {29'd0, bus_f.aref_en, bus_f.wr_en, bus_f.rd_en};
   endfunction

   function automatic logic [31:0] gnt_u();
      return {29'd0, bus_u.aref_en, bus_u.wr_en, bus_u.rd_en};
   endfunction

   // advance one clock; inputs are then driven 2 time units after the edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [2:0] exp_fair   [4];
   logic [2:0] exp_unfair [4];

   initial begin
      exp_fair[0]   = 3'b010; exp_fair[1]   = 3'b001;
      exp_fair[2]   = 3'b010; exp_fair[3]   = 3'b001;
      exp_unfair[0] = 3'b010; exp_unfair[1] = 3'b010;
      exp_unfair[2] = 3'b010; exp_unfair[3] = 3'b010;

      rst_f = 1'b1;
      rst_u = 1'b1;
      bus_f.init_end      = 1'b0;
      bus_f.init_cmd      = 4'b0010;
      bus_f.init_bank     = 2'b01;
      bus_f.init_addr     = 13'h0123;
      bus_f.aref_req      = 1'b0;
      bus_f.aref_end      = 1'b0;
      bus_f.aref_cmd      = 4'b0001;
      bus_f.aref_addr     = 13'h0400;
      bus_f.wr_req        = 1'b0;
      bus_f.wr_end        = 1'b0;
      bus_f.wr_sdram_cmd  = 4'b0011;
      bus_f.wr_sdram_bank = 2'b10;
      bus_f.wr_sdram_addr = 13'h00AB;
      bus_f.wr_sdram_en   = 1'b0;
      bus_f.wr_sdram_data = 16'hBEEF;
      bus_f.rd_req        = 1'b0;
      bus_f.rd_end        = 1'b0;
      bus_f.rd_sdram_cmd  = 4'b0101;
      bus_f.rd_sdram_bank = 2'b11;
      bus_f.rd_sdram_addr = 13'h0055;

      // ---- 1: reset state and init passthrough ----
      #12;
      chk("rst_cmd",   {28'd0, bus_f.sdram_cmd}, 32'h2);
      chk("rst_gnt",   gnt_f(), 32'h0);
      chk("rst_bank",  {30'd0, bus_f.sdram_bank}, 32'h1);
      chk("rst_addr",  {19'd0, bus_f.sdram_addr}, 32'h123);
      chk("rst_gnt_u", gnt_u(), 32'h0);
      rst_f = 1'b0;
      bus_f.wr_req = 1'b1;               // must be ignored while in IDLE
      tick();
      chk("idle_cmd", {28'd0, bus_f.sdram_cmd}, 32'h2);
      chk("idle_req_ignored", gnt_f(), 32'h0);
      bus_f.wr_req   = 1'b0;
      bus_f.init_end = 1'b1;
      tick();
      chk("arbit_cmd",  {28'd0, bus_f.sdram_cmd}, {28'd0, NOP});
      chk("arbit_addr", {19'd0, bus_f.sdram_addr}, 32'h0);
      chk("arbit_bank", {30'd0, bus_f.sdram_bank}, 32'h0);

      // ---- 2: single write ----
      bus_f.wr_req = 1'b1;
      tick();
      chk("wr_grant", gnt_f(), 32'h2);
      bus_f.wr_req = 1'b0;
      #1;
      chk("wr_cmd",   {28'd0, bus_f.sdram_cmd}, 32'h3);
      chk("wr_bank",  {30'd0, bus_f.sdram_bank}, 32'h2);
      chk("wr_addr",  {19'd0, bus_f.sdram_addr}, 32'hAB);
      chk("wr_oe_lo", {31'd0, bus_f.sdram_dq_oe}, 32'h0);
      chk("wr_dq_lo", {16'd0, bus_f.sdram_dq_out}, 32'h0);
      bus_f.wr_sdram_en  = 1'b1;
      bus_f.wr_sdram_cmd = 4'b0100;
      #1;
      chk("wr_cmd2",  {28'd0, bus_f.sdram_cmd}, 32'h4);
      chk("wr_oe_hi", {31'd0, bus_f.sdram_dq_oe}, 32'h1);
      chk("wr_dq_hi", {16'd0, bus_f.sdram_dq_out}, 32'hBEEF);
      tick();
      bus_f.wr_sdram_en = 1'b0;
      #1;
      chk("wr_oe_off", {31'd0, bus_f.sdram_dq_oe}, 32'h0);
      bus_f.wr_end = 1'b1;
      tick();
      bus_f.wr_end = 1'b0;
      chk("wr_end_gnt", gnt_f(), 32'h0);
      chk("wr_end_nop", {28'd0, bus_f.sdram_cmd}, {28'd0, NOP});
      bus_f.rd_end = 1'b1;               // stray end while ungranted
      tick();
      bus_f.rd_end = 1'b0;
      chk("stray_end", gnt_f(), 32'h0);

      // ---- 3: refresh beats write beats read ----
      bus_f.aref_req = 1'b1;
      bus_f.wr_req   = 1'b1;
      bus_f.rd_req   = 1'b1;
      tick();
      bus_f.aref_req = 1'b0;
      chk("pri_aref",      gnt_f(), 32'h4);
      chk("aref_cmd",      {28'd0, bus_f.sdram_cmd}, 32'h1);
      chk("aref_addr",     {19'd0, bus_f.sdram_addr}, 32'h400);
      chk("aref_bank",     {30'd0, bus_f.sdram_bank}, 32'h0);
      bus_f.wr_end = 1'b1;               // not the granted block
      tick();
      bus_f.wr_end = 1'b0;
      chk("aref_hold", gnt_f(), 32'h4);
      bus_f.aref_end = 1'b1;
      tick();
      bus_f.aref_end = 1'b0;
      chk("aref_gap", gnt_f(), 32'h0);
      chk("aref_gap_cmd", {28'd0, bus_f.sdram_cmd}, {28'd0, NOP});
      tick();
      chk("pri_wr", gnt_f(), 32'h2);
      bus_f.wr_req = 1'b0;
      bus_f.wr_end = 1'b1;
      tick();
      bus_f.wr_end = 1'b0;
      chk("wr_gap", gnt_f(), 32'h0);
      tick();
      chk("pri_rd", gnt_f(), 32'h1);
      bus_f.rd_req      = 1'b0;
      bus_f.wr_sdram_en = 1'b1;
      #1;
      chk("rd_cmd",  {28'd0, bus_f.sdram_cmd}, 32'h5);
      chk("rd_bank", {30'd0, bus_f.sdram_bank}, 32'h3);
      chk("rd_addr", {19'd0, bus_f.sdram_addr}, 32'h55);
      chk("rd_oe",   {31'd0, bus_f.sdram_dq_oe}, 32'h0);
      chk("rd_dq",   {16'd0, bus_f.sdram_dq_out}, 32'h0);
      bus_f.wr_sdram_en = 1'b0;
      bus_f.rd_end = 1'b1;
      tick();
      bus_f.rd_end = 1'b0;
      chk("rd_end_gnt", gnt_f(), 32'h0);

      // ---- 5: refresh request during a 10-beat read is not preemptive ----
      bus_f.rd_req = 1'b1;
      tick();
      chk("r10_grant", gnt_f(), 32'h1);
      bus_f.rd_req = 1'b0;
      tick();
      tick();
      tick();
      bus_f.aref_req = 1'b1;
      bus_f.wr_req   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("r10_beat%0d", i + 4), gnt_f(), 32'h1);
      end
      bus_f.rd_end = 1'b1;
      tick();
      bus_f.rd_end = 1'b0;
      chk("r10_gap", gnt_f(), 32'h0);
      tick();
      chk("r10_aref_first", gnt_f(), 32'h4);
      bus_f.aref_req = 1'b0;
      bus_f.aref_end = 1'b1;
      tick();
      bus_f.aref_end = 1'b0;
      chk("r10_aref_done", gnt_f(), 32'h0);
      tick();
      chk("r10_wr_after", gnt_f(), 32'h2);
      bus_f.wr_req = 1'b0;
      bus_f.wr_end = 1'b1;
      tick();
      bus_f.wr_end = 1'b0;
      chk("r10_wr_done", gnt_f(), 32'h0);

      // ---- 4: fair alternation vs. write-always ----
      rst_f = 1'b1;
      rst_u = 1'b1;
      #1;
      rst_f = 1'b0;
      rst_u = 1'b0;
      tick();                            // IDLE -> ARBIT (init_end still 1)
      chk("alt_arbit_f", {28'd0, bus_f.sdram_cmd}, {28'd0, NOP});
      chk("alt_arbit_u", {28'd0, bus_u.sdram_cmd}, {28'd0, NOP});
      bus_f.wr_req = 1'b1;
      bus_f.rd_req = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tick();
         chk($sformatf("alt_fair_b%0d", b),   gnt_f(), {29'd0, exp_fair[b]});
         chk($sformatf("alt_unfair_b%0d", b), gnt_u(), {29'd0, exp_unfair[b]});
         tick();
         bus_f.wr_end = 1'b1;            // only the granted block's end counts
         bus_f.rd_end = 1'b1;
         tick();
         bus_f.wr_end = 1'b0;
         bus_f.rd_end = 1'b0;
         chk($sformatf("alt_gap_f%0d", b), gnt_f(), 32'h0);
         chk($sformatf("alt_gap_u%0d", b), gnt_u(), 32'h0);
      end

      // ---- 6: asynchronous reset mid-write ----
      bus_f.rd_req = 1'b0;
      tick();
      chk("ar_wr_grant", gnt_f(), 32'h2);
      bus_f.wr_sdram_en = 1'b1;
      #1;
      chk("ar_oe_before", {31'd0, bus_f.sdram_dq_oe}, 32'h1);
      rst_f = 1'b1;                      // well away from any clock edge
      #1;
      chk("ar_gnt",  gnt_f(), 32'h0);
      chk("ar_cmd",  {28'd0, bus_f.sdram_cmd}, 32'h2);
      chk("ar_oe",   {31'd0, bus_f.sdram_dq_oe}, 32'h0);
      chk("ar_dq",   {16'd0, bus_f.sdram_dq_out}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
